// File: rtl/pack_build.sv
// pack_build: collects 16-bit trace words into 8-word TPIU frames held in a
// FRAMES-slot buffer, and releases a frame to the reader only once it is
// complete. The reader pops one word at a time and may rewind to the start
// of the frame it is reading; a frame stays resident until fully popped.
module pack_build #(
  parameter int FRAMES = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        WdAvail,
  input  logic        PacketReset,
  input  logic [15:0] PacketWd,
  input  logic        DataNext,
  input  logic        DataFrameReset,
  output logic [15:0] DataVal,
  output logic        DataReady,
  output logic        DataOverf
);

  localparam int DEPTH = FRAMES * 8;
  localparam int AW    = $clog2(DEPTH);
  localparam int PW    = AW + 1;
  localparam int FW    = PW - 3;
  localparam logic [FW-1:0] FRAMES_F = FW'(FRAMES);

  logic [PW-1:0] wptr_q, wptr_d;
  logic [PW-1:0] cptr_q, cptr_d;
  logic [PW-1:0] rptr_q, rptr_d;
  logic [2:0]    drop_q, drop_d;
  logic [15:0]   data_val_q, data_val_d;
  logic          ready_q, ready_d;
  logic          overf_q, overf_d;

  logic [15:0]   mem [DEPTH];
  logic          mem_we;
  logic [FW-1:0] used_frames;
  logic          slot_free;
  logic          pop_ok;

  // Frames held between the reader's current frame and the commit point;
  // a partially read frame still occupies its slot.
  assign used_frames = cptr_q[PW-1:3] - rptr_q[PW-1:3];
  assign slot_free   = (used_frames < FRAMES_F);
  assign pop_ok      = DataNext && ready_q && (rptr_q != cptr_q);

  // Write side: store, commit on the 8th word, drop whole frames when full.
  always_comb begin
    wptr_d  = wptr_q;
    cptr_d  = cptr_q;
    drop_d  = drop_q;
    overf_d = overf_q;
    mem_we  = 1'b0;
    if (DataFrameReset) begin
      overf_d = 1'b0;
    end
    if (PacketReset) begin
      wptr_d = cptr_q;
      drop_d = 3'd0;
    end else if (WdAvail) begin
      if (drop_q != 3'd0) begin
        drop_d = drop_q - 3'd1;
      end else if (slot_free) begin
        mem_we = 1'b1;
        wptr_d = wptr_q + PW'(1);
        if (wptr_q[2:0] == 3'd7) begin
          cptr_d = wptr_q + PW'(1);
        end
      end else if (wptr_q[2:0] == 3'd0) begin
        drop_d  = 3'd7;
        overf_d = 1'b1;
      end
    end
  end

  // Read side: rewind has priority over pop; DataReady is a registered compare.
  always_comb begin
    rptr_d     = rptr_q;
    data_val_d = data_val_q;
    ready_d    = (rptr_q != cptr_q);
    if (DataFrameReset) begin
      rptr_d = {rptr_q[PW-1:3], 3'b000};
    end else if (pop_ok) begin
      data_val_d = mem[rptr_q[AW-1:0]];
      rptr_d     = rptr_q + PW'(1);
    end
  end

  // Frame buffer storage; contents need no reset since pointers gate access.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem[wptr_q[AW-1:0]] <= PacketWd;
    end
  end

  // State registers; async reset returns the block to the empty state.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wptr_q     <= '0;
      cptr_q     <= '0;
      rptr_q     <= '0;
      drop_q     <= '0;
      data_val_q <= '0;
      ready_q    <= 1'b0;
      overf_q    <= 1'b0;
    end else begin
      wptr_q     <= wptr_d;
      cptr_q     <= cptr_d;
      rptr_q     <= rptr_d;
      drop_q     <= drop_d;
      data_val_q <= data_val_d;
      ready_q    <= ready_d;
      overf_q    <= overf_d;
    end
  end

  assign DataVal   = data_val_q;
  assign DataReady = ready_q;
  assign DataOverf = overf_q;

endmodule

// File: tb/tb_pack_build.sv
// tb_pack_build: directed scenarios followed by a randomized phase, all
// compared every cycle against a frame-level reference model built from
// queues of committed and partial words.
module tb_pack_build;

  localparam int FRAMES = 8;

  logic        clk;
  logic        rst;
  logic        WdAvail;
  logic        PacketReset;
  logic [15:0] PacketWd;
  logic        DataNext;
  logic        DataFrameReset;
  logic [15:0] DataVal;
  logic        DataReady;
  logic        DataOverf;

  int checks = 0;
  int errors = 0;

  // Reference model: committed-but-unreleased words, the frame being built,
  // the read offset inside the head frame, and the expected outputs.
  logic [15:0] cq[$];
  logic [15:0] partial[$];
  int          rdIdx;
  int          dropping;
  bit          expOverf;
  bit          expReady;
  logic [15:0] expVal;

  pack_build #(.FRAMES(FRAMES)) dut (
    .clk           (clk),
    .rst           (rst),
    .WdAvail       (WdAvail),
    .PacketReset   (PacketReset),
    .PacketWd      (PacketWd),
    .DataNext      (DataNext),
    .DataFrameReset(DataFrameReset),
    .DataVal       (DataVal),
    .DataReady     (DataReady),
    .DataOverf     (DataOverf)
  );

  // Free-running clock, period 10.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Empty buffer, nothing pending, outputs at their reset values.
  task automatic modelReset();
    cq.delete();
    partial.delete();
    rdIdx    = 0;
    dropping = 0;
    expOverf = 1'b0;
    expReady = 1'b0;
    expVal   = 16'h0000;
  endtask

  // Advance the model by one clock edge using the values present before it.
  task automatic modelClock(input bit wa, input bit pr, input logic [15:0] wd,
                            input bit dn, input bit dfr);
    bit oldUnread;
    int oldOcc;
    oldUnread = (cq.size() > 0);
    oldOcc    = cq.size() / 8;
    if (dfr) expOverf = 1'b0;
    if (pr) begin
      partial.delete();
      dropping = 0;
    end else if (wa) begin
      if (dropping > 0) begin
        dropping--;
      end else if (partial.size() == 0 && oldOcc >= FRAMES) begin
        dropping = 7;
        expOverf = 1'b1;
      end else begin
        partial.push_back(wd);
        if (partial.size() == 8) begin
          for (int i = 0; i < 8; i++) cq.push_back(partial[i]);
          partial.delete();
        end
      end
    end
    if (dfr) begin
      rdIdx = 0;
    end else if (dn && expReady && oldUnread) begin
      expVal = cq[rdIdx];
      rdIdx++;
      if (rdIdx == 8) begin
        for (int i = 0; i < 8; i++) cq.delete(0);
        rdIdx = 0;
      end
    end
    expReady = oldUnread;
  endtask

  // Compare all three outputs against the model.
  task automatic checkOutput(input string tag);
    checks++;
    assert (DataReady === expReady) else begin
      errors++;
      $error("[TB] FAIL %s DataReady observed %b expected %b", tag, DataReady, expReady);
    end
    checks++;
    assert (DataOverf === expOverf) else begin
      errors++;
      $error("[TB] FAIL %s DataOverf observed %b expected %b", tag, DataOverf, expOverf);
    end
    checks++;
    assert (DataVal === expVal) else begin
      errors++;
      $error("[TB] FAIL %s DataVal observed %h expected %h", tag, DataVal, expVal);
    end
  endtask

  // Drive one cycle of inputs, step the model at the edge, check 1 time unit later.
  task automatic applyStimulus(input bit wa, input bit pr, input logic [15:0] wd,
                               input bit dn, input bit dfr, input string tag);
    WdAvail        = wa;
    PacketReset    = pr;
    PacketWd       = wd;
    DataNext       = dn;
    DataFrameReset = dfr;
    @(posedge clk);
    modelClock(wa, pr, wd, dn, dfr);
    #1;
    checkOutput(tag);
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) applyStimulus(1'b0, 1'b0, 16'h0, 1'b0, 1'b0, "idle");
  endtask

  task automatic writeWord(input logic [15:0] w);
    applyStimulus(1'b1, 1'b0, w, 1'b0, 1'b0, "write");
  endtask

  // Pop followed by a quiet cycle, keeping the two-cycle request cadence.
  task automatic popWord();
    applyStimulus(1'b0, 1'b0, 16'h0, 1'b1, 1'b0, "pop");
    idle(1);
  endtask

  // Fixed-value checks taken straight from the scenario description.
  task automatic expectVal(input logic [15:0] v, input string tag);
    checks++;
    assert (DataVal === v) else begin
      errors++;
      $error("[TB] FAIL %s DataVal observed %h expected %h", tag, DataVal, v);
    end
  endtask

  task automatic expectReady(input bit v, input string tag);
    checks++;
    assert (DataReady === v) else begin
      errors++;
      $error("[TB] FAIL %s DataReady observed %b expected %b", tag, DataReady, v);
    end
  endtask

  task automatic expectOverf(input bit v, input string tag);
    checks++;
    assert (DataOverf === v) else begin
      errors++;
      $error("[TB] FAIL %s DataOverf observed %b expected %b", tag, DataOverf, v);
    end
  endtask

  // Directed scenarios, then randomized traffic, then the summary.
  initial begin
    logic [15:0] t2Words [8];
    bit          wa, pr, dn, dfr;
    logic [15:0] wd;

    t2Words = '{16'h0010, 16'h1101, 16'h1202, 16'h1303,
                16'h1404, 16'h1505, 16'h1606, 16'h1807};

    rst = 1'b0;
    WdAvail = 1'b0; PacketReset = 1'b0; PacketWd = 16'h0;
    DataNext = 1'b0; DataFrameReset = 1'b0;
    modelReset();
    #12;
    checkOutput("reset");
    expectVal(16'h0000, "reset DataVal");
    rst = 1'b1;
    idle(2);

    $display("[TB] partial frame never becomes ready");
    for (int i = 0; i < 7; i++) begin
      writeWord(16'(32'h1000 + i));
      expectReady(1'b0, "partial7");
    end
    idle(2);
    expectReady(1'b0, "partial7 settle");
    applyStimulus(1'b0, 1'b1, 16'h0, 1'b0, 1'b0, "pktreset");

    $display("[TB] full frame commit and ordered read");
    for (int i = 0; i < 8; i++) writeWord(t2Words[i]);
    expectReady(1'b0, "commit edge N");
    idle(1);
    expectReady(1'b1, "commit edge N+1");
    for (int i = 0; i < 8; i++) begin
      popWord();
      expectVal(t2Words[i], "frame read");
    end
    expectReady(1'b0, "drained");

    $display("[TB] PacketReset discards partial frame");
    for (int i = 0; i < 5; i++) writeWord(16'(32'h5000 + i));
    applyStimulus(1'b1, 1'b1, 16'h5555, 1'b0, 1'b0, "pktreset+wa");
    for (int i = 0; i < 8; i++) writeWord(16'(32'hA000 + i));
    idle(1);
    for (int i = 0; i < 8; i++) begin
      popWord();
      expectVal(16'(32'hA000 + i), "after pktreset");
    end
    expectReady(1'b0, "pktreset drained");

    $display("[TB] rewind to frame start");
    for (int i = 0; i < 8; i++) writeWord(16'(32'hB000 + i));
    idle(1);
    for (int i = 0; i < 3; i++) popWord();
    expectVal(16'hB002, "before rewind");
    applyStimulus(1'b0, 1'b0, 16'h0, 1'b1, 1'b1, "rewind+next");
    expectVal(16'hB002, "rewind ignores next");
    idle(1);
    for (int i = 0; i < 8; i++) begin
      popWord();
      expectVal(16'(32'hB000 + i), "after rewind");
    end
    expectReady(1'b0, "rewind drained");

    $display("[TB] overflow on ninth frame");
    for (int f = 0; f < 9; f++)
      for (int i = 0; i < 8; i++) writeWord(16'(32'hC000 + f * 16 + i));
    expectOverf(1'b1, "overflow set");
    idle(1);
    for (int f = 0; f < 8; f++)
      for (int i = 0; i < 8; i++) begin
        popWord();
        expectVal(16'(32'hC000 + f * 16 + i), "overflow read");
      end
    expectReady(1'b0, "ninth frame absent");
    expectOverf(1'b1, "overflow sticky");
    applyStimulus(1'b0, 1'b0, 16'h0, 1'b0, 1'b1, "clear overf");
    expectOverf(1'b0, "overflow cleared");

    $display("[TB] slot reuse across wrap");
    for (int f = 0; f < 8; f++)
      for (int i = 0; i < 8; i++) writeWord(16'(32'hD000 + f * 16 + i));
    idle(1);
    for (int i = 0; i < 8; i++) begin
      popWord();
      expectVal(16'(32'hD000 + i), "wrap first frame");
    end
    for (int i = 0; i < 8; i++) writeWord(16'(32'hE000 + i));
    idle(1);
    expectOverf(1'b0, "wrap no overflow");
    for (int f = 1; f < 8; f++)
      for (int i = 0; i < 8; i++) begin
        popWord();
        expectVal(16'(32'hD000 + f * 16 + i), "wrap old frames");
      end
    for (int i = 0; i < 8; i++) begin
      popWord();
      expectVal(16'(32'hE000 + i), "wrap new frame");
    end
    expectReady(1'b0, "wrap drained");

    $display("[TB] asynchronous reset mid-frame");
    for (int i = 0; i < 8; i++) writeWord(16'(32'hF000 + i));
    idle(1);
    popWord();
    popWord();
    for (int i = 0; i < 3; i++) writeWord(16'(32'hF100 + i));
    rst = 1'b0;
    #2;
    modelReset();
    checkOutput("async reset");
    WdAvail = 1'b0; PacketReset = 1'b0; DataNext = 1'b0; DataFrameReset = 1'b0;
    rst = 1'b1;
    idle(2);
    expectReady(1'b0, "after async reset");
    for (int i = 0; i < 8; i++) writeWord(16'(32'h7700 + i));
    idle(1);
    popWord();
    expectVal(16'h7700, "post reset frame");

    $display("[TB] randomized traffic");
    for (int c = 0; c < 800; c++) begin
      wa  = ($urandom_range(0, 99) < ((c < 400) ? 60 : 25));
      pr  = ($urandom_range(0, 99) < 3);
      dn  = ((c % 2) == 0) && ($urandom_range(0, 99) < 75);
      dfr = ($urandom_range(0, 99) < 3);
      wd  = 16'($urandom);
      applyStimulus(wa, pr, wd, dn, dfr, "random");
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
